// File: rtl/fft_ctrl_pkg.sv
// Shared types and sizing helpers for the FFT sequencer.
package fft_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_COEF, S_CALC, S_WAIT, S_FEED, S_DRAIN
  } state_e;

  function automatic int num_stages(input int n);
    return $clog2(n);
  endfunction

  function automatic int cnt_w(input int n);
    return $clog2(n);
  endfunction

  // Internal stage counter must reach num_stages-1 and also cover the datapath port.
  function automatic int stage_w(input int n);
    int port_w;
    int req_w;
    port_w = $clog2(n / 4);
    req_w  = $clog2($clog2(n));
    return (port_w > req_w) ? port_w : req_w;
  endfunction

endpackage

// File: rtl/fft_word_sel.sv
// Combinational N:1 word slice of the datapath output bus.
module fft_word_sel
  import fft_ctrl_pkg::*;
#(
  parameter int N   = 16,
  parameter int MSB = 16
) (
  input  logic [N*MSB-1:0]     data_i,
  input  logic [cnt_w(N)-1:0]  sel_i,
  output logic [MSB-1:0]       word_o
);

  localparam int IW = cnt_w(N);

  always_comb begin
    word_o = '0;
    for (int k = 0; k < N; k++) begin
      if (sel_i == IW'(k)) word_o = data_i[k*MSB +: MSB];
    end
  end

endmodule

// File: rtl/fft_seq_ctrl.sv
// Frame sequencer for the fft_reg_stage datapath: load, per-stage coef/calc/feed, drain.
// Optional FFT_CTRL_CYCLE_CNT_EN adds a saturating busy-cycle counter output.
module fft_seq_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter int N         = 16,
  parameter int MSB       = 16,
  parameter int COEF_WAIT = N/2 + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [MSB-1:0]          in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [MSB-1:0]          out_data,
  output logic                    done,
  output logic                    busy,
  output logic                    fill_regs,
  output logic                    start_calc,
  output logic [$clog2(N)-1:0]    addr_counter,
  output logic [$clog2(N/4)-1:0]  stage,
  output logic [MSB-1:0]          data_in,
  input  logic [N*MSB-1:0]        fft_data_out,
  input  logic                    calc_finish
`ifdef FFT_CTRL_CYCLE_CNT_EN
  ,
  output logic [15:0]             cycle_cnt
`endif
);

  localparam int NUM_STAGES = num_stages(N);
  localparam int CW = cnt_w(N);
  localparam int SW = stage_w(N);
  localparam int PW = $clog2(N/4);
  localparam int WW = (COEF_WAIT < 1) ? 1 : $clog2(COEF_WAIT + 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic [SW-1:0]   stage_q, stage_d;
  logic [CW-1:0]   addr_q, addr_d;
  logic [MSB-1:0]  data_q, data_d;
  logic            done_q, done_d;
  logic [CW-1:0]   sel;
  logic [MSB-1:0]  word;

  // FEED looks one word ahead because the WAIT->FEED edge already wrote word 0.
  always_comb begin
    sel = cnt_q;
    if (state_q == S_WAIT)      sel = '0;
    else if (state_q == S_FEED) sel = cnt_q + CW'(1);
  end

  fft_word_sel #(.N(N), .MSB(MSB)) u_word_sel (
    .data_i (fft_data_out),
    .sel_i  (sel),
    .word_o (word)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    stage_d = stage_q;
    addr_d  = addr_q;
    data_d  = data_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: if (start) begin
        state_d = S_LOAD;
        stage_d = '0;
        cnt_d   = '0;
      end
      S_LOAD: if (in_valid) begin
        addr_d = cnt_q;
        data_d = in_data;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(N-1)) begin
          state_d = S_COEF;
          wait_d  = '0;
        end
      end
      S_COEF: begin
        if (wait_q == WW'(COEF_WAIT)) state_d = S_CALC;
        else                          wait_d  = wait_q + WW'(1);
      end
      S_CALC: state_d = S_WAIT;
      S_WAIT: if (calc_finish) begin
        cnt_d = '0;
        if (stage_q == SW'(NUM_STAGES-1)) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_FEED;
          stage_d = stage_q + SW'(1);
          addr_d  = '0;
          data_d  = word;
        end
      end
      S_FEED: begin
        if (cnt_q == CW'(N-1)) begin
          state_d = S_COEF;
          wait_d  = '0;
        end else begin
          cnt_d  = cnt_q + CW'(1);
          addr_d = cnt_q + CW'(1);
          data_d = word;
        end
      end
      S_DRAIN: if (out_ready) begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N-1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wait_q  <= '0;
      stage_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      stage_q <= stage_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  assign in_ready     = (state_q == S_LOAD);
  assign out_valid    = (state_q == S_DRAIN);
  assign out_data     = (state_q == S_DRAIN) ? word : '0;
  assign busy         = (state_q != S_IDLE);
  assign fill_regs    = (state_q == S_COEF) && (wait_q == '0);
  assign start_calc   = (state_q == S_CALC);
  assign done         = done_q;
  assign addr_counter = addr_q;
  assign data_in      = data_q;
  assign stage        = stage_q[PW-1:0];

`ifdef FFT_CTRL_CYCLE_CNT_EN
  logic [15:0] cyc_q, cyc_d;

  always_comb begin
    cyc_d = cyc_q;
    if (state_q == S_IDLE) begin
      if (start) cyc_d = '0;
    end else if (cyc_q != 16'hFFFF) begin
      cyc_d = cyc_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc_q <= '0;
    else        cyc_q <= cyc_d;
  end

  assign cycle_cnt = cyc_q;
`endif

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Bench for fft_seq_ctrl with a behavioural datapath and an output scoreboard.
module tb_fft_seq_ctrl;

  localparam int N   = 16;
  localparam int MSB = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic calc_finish = 1'b0;
  logic [MSB-1:0] in_data = '0;
  logic in_ready, out_valid, done, busy, fill_regs, start_calc;
  logic [MSB-1:0] out_data, data_in;
  logic [3:0] addr_counter;
  logic [1:0] stage;
  logic [N*MSB-1:0] fft_data_out = '0;
`ifdef FFT_CTRL_CYCLE_CNT_EN
  logic [15:0] cycle_cnt;
`endif

  int total = 0;
  int bad = 0;
  int calc_pulses = 0;
  int base_pulses = 0;
  int timer = 0;
  logic [15:0] exp_q[$];
  logic [15:0] samp[16];
  logic [15:0] bank[16];
  logic [15:0] pend[16];

  always #5 clk = ~clk;

  fft_seq_ctrl #(.N(N), .MSB(MSB), .COEF_WAIT(9)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .done         (done),
    .busy         (busy),
    .fill_regs    (fill_regs),
    .start_calc   (start_calc),
    .addr_counter (addr_counter),
    .stage        (stage),
    .data_in      (data_in),
    .fft_data_out (fft_data_out),
    .calc_finish  (calc_finish)
`ifdef FFT_CTRL_CYCLE_CNT_EN
    ,
    .cycle_cnt    (cycle_cnt)
`endif
  );

  // Datapath stand-in: bank written every cycle, each stage rotates by one and adds a stage offset.
  always @(negedge clk) begin
    if (!rst_n) begin
      timer = 0;
      calc_finish = 1'b0;
    end else begin
      bank[addr_counter] = data_in;
      calc_finish = 1'b0;
      if (timer > 0) begin
        timer--;
        if (timer == 0) begin
          for (int k = 0; k < N; k++) fft_data_out[k*MSB +: MSB] = pend[k];
          calc_finish = 1'b1;
        end
      end
      if (start_calc) begin
        calc_pulses++;
        for (int k = 0; k < N; k++)
          pend[k] = bank[(k+1)%N] + (16'(stage) + 16'd1) * 16'h0101;
        timer = 5;
      end
    end
  end

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({in_ready, out_valid, done, busy, fill_regs, start_calc} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b exp=000000", {in_ready, out_valid, done, busy, fill_regs, start_calc});
    end
    total++;
    if (addr_counter !== 4'd0 || stage !== 2'd0 || data_in !== 16'd0 || out_data !== 16'd0) begin
      bad++;
      $display("FAIL reset_data got addr=%0d stage=%0d data=%h out=%h exp all 0", addr_counter, stage, data_in, out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({in_ready, out_valid, done, busy, fill_regs, start_calc} !== 6'b0 ||
        addr_counter !== 4'd0 || data_in !== 16'd0) begin
      bad++;
      $display("FAIL reset_release got ctrl=%b addr=%0d data=%h exp zeros",
               {in_ready, out_valid, done, busy, fill_regs, start_calc}, addr_counter, data_in);
    end
  endtask

  task automatic test_load(input bit with_stall);
    logic [15:0] x[16];
    logic [15:0] y[16];
    for (int k = 0; k < N; k++) samp[k] = 16'($urandom_range(0, 65535));
    x = samp;
    for (int st = 0; st < 4; st++) begin
      for (int k = 0; k < N; k++) y[k] = x[(k+1)%N] + 16'((st + 1) * 257);
      x = y;
    end
    for (int k = 0; k < N; k++) exp_q.push_back(x[k]);
    base_pulses = calc_pulses;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL load_busy got=%b exp=1", busy);
    end
    for (int i = 0; i < N; i++) begin
      if (with_stall && i == 8) begin
        in_valid = 1'b0;
        repeat (3) begin
          @(negedge clk);
          total++;
          if (addr_counter !== 4'd7 || data_in !== samp[7] || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL stall_hold got addr=%0d data=%h rdy=%b exp addr=7 data=%h rdy=1",
                     addr_counter, data_in, in_ready, samp[7]);
          end
        end
      end
      total++;
      if (in_ready !== 1'b1) begin
        bad++;
        $display("FAIL load_ready i=%0d got=%b exp=1", i, in_ready);
      end
      in_valid = 1'b1;
      in_data = samp[i];
      @(negedge clk);
      total++;
      if (addr_counter !== 4'(i) || data_in !== samp[i]) begin
        bad++;
        $display("FAIL load_pair i=%0d got addr=%0d data=%h exp addr=%0d data=%h",
                 i, addr_counter, data_in, i, samp[i]);
      end
    end
    in_valid = 1'b0;
    in_data = '0;
    total++;
    if (fill_regs !== 1'b1 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL load_fill got fill=%b rdy=%b exp fill=1 rdy=0", fill_regs, in_ready);
    end
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      total++;
      if (start_calc !== 1'(j == 10) || fill_regs !== 1'b0) begin
        bad++;
        $display("FAIL load_start_calc j=%0d got sc=%b fill=%b exp sc=%b fill=0",
                 j, start_calc, fill_regs, (j == 10));
      end
    end
  endtask

  task automatic test_stage_loop();
    int waited;
    total++;
    if (stage !== 2'd0) begin
      bad++;
      $display("FAIL stage_first got=%0d exp=0", stage);
    end
    for (int s = 0; s < 3; s++) begin
      waited = 0;
      while (stage !== 2'(s+1) && waited < 30) begin
        start = (s == 1);
        @(negedge clk);
        waited++;
      end
      start = 1'b0;
      total++;
      if (waited >= 30) begin
        bad++;
        $display("FAIL stage_advance got stage=%0d exp=%0d", stage, s + 1);
        return;
      end
      for (int k = 0; k < N; k++) begin
        total++;
        if (addr_counter !== 4'(k) || data_in !== fft_data_out[k*MSB +: MSB] || stage !== 2'(s+1)) begin
          bad++;
          $display("FAIL feed_pair s=%0d k=%0d got addr=%0d data=%h stage=%0d exp addr=%0d data=%h stage=%0d",
                   s, k, addr_counter, data_in, stage, k, fft_data_out[k*MSB +: MSB], s + 1);
        end
        @(negedge clk);
      end
      total++;
      if (fill_regs !== 1'b1) begin
        bad++;
        $display("FAIL feed_fill s=%0d got=%b exp=1", s, fill_regs);
      end
      repeat (10) @(negedge clk);
      total++;
      if (start_calc !== 1'b1 || stage !== 2'(s+1)) begin
        bad++;
        $display("FAIL stage_start s=%0d got sc=%b stage=%0d exp sc=1 stage=%0d", s, start_calc, stage, s + 1);
      end
    end
    waited = 0;
    while (out_valid !== 1'b1 && waited < 30) begin
      @(negedge clk);
      waited++;
    end
    total++;
    if (waited >= 30) begin
      bad++;
      $display("FAIL drain_entry got out_valid=%b exp=1", out_valid);
    end
    total++;
    if (calc_pulses - base_pulses != 4 || stage !== 2'd3) begin
      bad++;
      $display("FAIL calc_pulses got=%0d stage=%0d exp=4 stage=3", calc_pulses - base_pulses, stage);
    end
  endtask

  task automatic test_drain();
    int got = 0;
    int cyc = 0;
    bit tog = 1'b1;
    bit was_stall = 1'b0;
    logic [15:0] held = '0;
    logic [15:0] expw;
    while (got < N && cyc < 80) begin
      total++;
      if (out_valid !== 1'b1) begin
        bad++;
        $display("FAIL drain_valid cyc=%0d got=%b exp=1", cyc, out_valid);
      end
      if (was_stall) begin
        total++;
        if (out_data !== held) begin
          bad++;
          $display("FAIL drain_hold got=%h exp=%h", out_data, held);
        end
      end
      out_ready = tog;
      if (tog) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL drain_extra got=%h exp none", out_data);
        end else begin
          expw = exp_q.pop_front();
          total++;
          if (out_data !== expw) begin
            bad++;
            $display("FAIL drain_data idx=%0d got=%h exp=%h", got, out_data, expw);
          end
        end
        got++;
        was_stall = 1'b0;
      end else begin
        held = out_data;
        was_stall = 1'b1;
      end
      tog = ~tog;
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    total++;
    if (got != N) begin
      bad++;
      $display("FAIL drain_count got=%0d exp=%0d", got, N);
    end
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL drain_done got done=%b busy=%b vld=%b exp 1 0 0", done, busy, out_valid);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL done_pulse got=%b exp=0", done);
    end
  endtask

  task automatic test_abort();
    int waited = 0;
    test_load(1'b0);
    while (!(stage === 2'd2 && start_calc === 1'b1) && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    total++;
    if (waited >= 200) begin
      bad++;
      $display("FAIL abort_reach got stage=%0d exp=2", stage);
    end
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || stage !== 2'd0 || addr_counter !== 4'd0 || data_in !== 16'd0 || start_calc !== 1'b0) begin
      bad++;
      $display("FAIL abort_reset got busy=%b stage=%0d addr=%0d data=%h exp zeros", busy, stage, addr_counter, data_in);
    end
    exp_q.delete();
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL abort_idle got busy=%b rdy=%b exp 0 0", busy, in_ready);
    end
    test_load(1'b0);
    test_stage_loop();
    test_drain();
  endtask

  initial begin
    test_reset();
    test_load(1'b0);
    test_stage_loop();
    test_drain();
    test_load(1'b1);
    test_stage_loop();
    test_drain();
    test_abort();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fft_seq_ctrl.md
# fft_seq_ctrl

Sequencer for the `fft_reg_stage` datapath: one frame of N samples in, N transformed words out.
- Accepts N input samples over a valid/ready stream and drives `addr_counter`/`data_in` to load the input register bank.
- Steps `stage` through all log2(N) FFT stages. For each stage it pulses `fill_regs` to rebuild the coefficient bank, pulses `start_calc`, then waits for `calc_finish`.
- Between stages it feeds `fft_data_out` back into the input bank.
- After the last stage it streams the N results out.

## Interface
Parameters:
- N, 16, FFT points; power of two, ≥8
- MSB, 16, word width
- COEF_WAIT, N/2+1, cycles between `fill_regs` pulse and `start_calc`

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a frame; sampled only in IDLE
- in_valid  in  1  input sample valid
- in_ready  out  1  controller accepts sample
- in_data  in  MSB  input sample
- out_valid  out  1  result word valid
- out_ready  in  1  downstream accepts result
- out_data  out  MSB  result word, natural index order
- done  out  1  one-cycle pulse after last result accepted
- busy  out  1  high in every state except IDLE
- fill_regs  out  1  to datapath, one-cycle pulse
- start_calc  out  1  to datapath, one-cycle pulse
- addr_counter  out  $clog2(N)  to datapath
- stage  out  $clog2(N/4)  to datapath
- data_in  out  MSB  to datapath
- fft_data_out  in  N*MSB  from datapath; word k = bits [k*MSB +: MSB]
- calc_finish  in  1  from datapath

## Operation
NUM_STAGES = $clog2(N).

State machine (IDLE, LOAD, COEF, CALC, WAIT, FEED, DRAIN):
- IDLE: `start`=1 → LOAD; `stage`←0; element counter ←0. `start` in any other state is ignored.
- LOAD: `in_ready`=1. On accept: `addr_counter`←count; `data_in`←`in_data`; count++. After the N-th accept → COEF.
- COEF: `fill_regs`=1 on the entry cycle only. Wait counter runs COEF_WAIT cycles → CALC.
- CALC: `start_calc`=1 for exactly one cycle → WAIT.
- WAIT: on `calc_finish`=1:
  - if `stage`==NUM_STAGES-1 → DRAIN;
  - else `stage`++ → FEED.
  - `calc_finish` in any other state is ignored.
- FEED: N cycles, unconditional. Cycle k: `addr_counter`←k, `data_in`←`fft_data_out` word k. After k=N-1 → COEF.
- DRAIN: `out_valid`=1; `out_data`=`fft_data_out` word (count). Advance on `out_ready`. After N-th handshake → IDLE and `done`=1 for one cycle.

Write-pair rule:
- The datapath input bank writes every cycle. `addr_counter` and `data_in` are registered and update only together.
- Outside LOAD/FEED accept cycles the pair holds the last written element, so the rewrite is idempotent.
- On the WAIT→FEED edge, `stage` and the first FEED pair update on the same clock.

## Timing
- Reset values: `in_ready`, `out_valid`, `done`, `busy`, `fill_regs`, `start_calc` = 0; `addr_counter`, `stage`, `data_in` = 0; state = IDLE.
- Asserting `rst_n` low at any time, including mid-WAIT or mid-DRAIN, forces the reset values asynchronously. The frame is dropped.
- `fill_regs` rises on the cycle after the N-th LOAD accept, and one cycle after the last FEED write.
- `start_calc` rises COEF_WAIT+1 cycles after the `fill_regs` cycle.
- `fft_data_out` must stay stable from `calc_finish` until the next `start_calc`. The controller does not snapshot it.
- Datapath-limited frame latency: N + NUM_STAGES·(COEF_WAIT+2+T_calc) + (NUM_STAGES-1)·N + N, with full-rate handshakes.
- `out_data`/`out_valid` are held stable while `out_ready`=0.

## Configuration
- FFT_CTRL_CYCLE_CNT_EN defined:
  - adds output `cycle_cnt` (16 bits, saturating);
  - cleared on IDLE→LOAD, increments every busy cycle, frozen in IDLE;
  - reset value 0.
- Undefined: the port and its counter are absent.

## Structure
- Package `fft_ctrl_pkg` holds:
  - the state enum;
  - function `num_stages(N)`;
  - the element-counter and stage widths.
- One sub-module, `fft_word_sel`: a combinational N:1 word slice of `fft_data_out`, shared by FEED and DRAIN.

## Test plan
All scenarios use N=16, COEF_WAIT=9.
- Reset: `rst_n`=0 → all outputs 0, `busy`=0; releasing it leaves the block in IDLE with outputs unchanged.
- Load: `start`, then `in_data`=0..15 at full rate → `in_ready` high 16 cycles, `addr_counter` 0..15 paired with data, `fill_regs` pulse on the next cycle, `start_calc` 10 cycles later.
- Stall: `in_valid` deasserted for 3 cycles mid-LOAD → `addr_counter`/`data_in` hold; count resumes with no lost or duplicated sample.
- Stage loop: model returns `calc_finish` 5 cycles after each `start_calc` → `stage` 0,1,2,3; 16 FEED writes between stages; exactly 4 `start_calc` pulses; `start` during busy ignored.
- Drain: `out_ready` toggling 1,0 → 16 words match model words 0..15 in order; `done` pulses once.
- Abort: `rst_n` low during WAIT of stage 2 → IDLE; a fresh frame then completes correctly.
